// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the fetch queue and its read port.
package fetch_pkg;

    localparam int unsigned FETCH_LANES = 8;
    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned PC_W        = 64;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

    // Occupancy needs one bit more than a pointer so that "full" is representable.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ring_rdport8.sv
// Combinational 8-lane read of a circular array starting at base, wrapping modulo DEPTH.
module ring_rdport8
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 32,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  fetch_entry_t     mem  [DEPTH],
    input  logic [PTR_W-1:0] base,
    output fetch_entry_t     lane [FETCH_LANES]
);

    for (genvar i = 0; i < FETCH_LANES; i++) begin : g_lane
        assign lane[i] = mem[base + PTR_W'(i)];
    end

endmodule

// File: rtl/fetch_queue8w.sv
// Circular instruction buffer between fetch and the 8-wide decoder: packed bundle
// push at tail, oldest-first 8-lane window at head, flush to empty.
module fetch_queue8w
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 32,
    parameter  int unsigned LANES = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = cnt_w(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush_i,
    input  logic                            fetch_valid_i,
    input  logic [3:0]                      fetch_count_i,
    input  logic [LANES-1:0][INSTR_W-1:0]   fetch_instr_i,
    input  logic [LANES-1:0][PC_W-1:0]      fetch_pc_i,
    output logic                            fetch_ready_o,
    output logic [LANES-1:0]                dec_valid_o,
    output logic [LANES-1:0][INSTR_W-1:0]   dec_instr_o,
    output logic [LANES-1:0][PC_W-1:0]      dec_pc_o,
    input  logic                            dec_ready_i,
    output logic [CNT_W-1:0]                count_o,
    output logic                            empty_o
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [3:0]       push_cnt;
    logic             do_push;
    logic [3:0]       npush;
    logic [3:0]       npop;
    logic [CNT_W-1:0] count_next;

    fetch_entry_t     wr_lane [FETCH_LANES];
    logic             wr_en   [DEPTH];
    fetch_entry_t     wr_data [DEPTH];
    fetch_entry_t     rd_lane [FETCH_LANES];

    // Ready looks only at registered occupancy, so there is no path from dec_ready_i.
    assign fetch_ready_o = (count <= CNT_W'(DEPTH - FETCH_LANES));

    always_comb begin : p_ctrl
        push_cnt = (fetch_count_i > 4'd8) ? 4'd8 : fetch_count_i;
        do_push  = fetch_valid_i && fetch_ready_o && !flush_i;
        npush    = do_push ? push_cnt : 4'd0;
        npop     = 4'd0;
        if (dec_ready_i && !flush_i) begin
            npop = (count >= CNT_W'(FETCH_LANES)) ? 4'(FETCH_LANES) : 4'(count);
        end
        count_next = count + CNT_W'(npush) - CNT_W'(npop);
    end

    // Pointers and occupancy; flush behaves exactly like reset.
    always_ff @(posedge clk) begin : p_state
        if (!rst_n || flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(npop);
            tail  <= tail + PTR_W'(npush);
            count <= count_next;
        end
    end

    for (genvar k = 0; k < FETCH_LANES; k++) begin : g_wr_lane
        assign wr_lane[k] = '{instr: fetch_instr_i[k], pc: fetch_pc_i[k]};
    end

    // Each entry picks its lane by distance from tail; entries outside the bundle hold.
    always_comb begin : p_wr_sel
        logic [PTR_W-1:0] off;
        off = '0;
        for (int j = 0; j < DEPTH; j++) begin
            off        = PTR_W'(j) - tail;
            wr_en[j]   = do_push && (off < PTR_W'(push_cnt));
            wr_data[j] = wr_lane[off[2:0]];
        end
    end

    always_ff @(posedge clk) begin : p_store
        for (int j = 0; j < DEPTH; j++) begin
            if (wr_en[j]) begin
                mem[j] <= wr_data[j];
            end
        end
    end

    ring_rdport8 #(
        .DEPTH (DEPTH)
    ) u_rdport (
        .mem  (mem),
        .base (head),
        .lane (rd_lane)
    );

    // Invalid lanes are forced to zero so the decoder never sees stale storage.
    always_comb begin : p_dec
        logic vld;
        vld = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            vld            = (CNT_W'(i) < count);
            dec_valid_o[i] = vld;
            dec_instr_o[i] = vld ? rd_lane[i].instr : '0;
            dec_pc_o[i]    = vld ? rd_lane[i].pc    : '0;
        end
    end

    assign count_o = count;
    assign empty_o = (count == '0);

endmodule

// File: tb/tb_fetch_queue8w.sv
// Directed vector bench for fetch_queue8w: table of single-cycle steps plus a wrap sequence.
module tb_fetch_queue8w;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush_i;
    logic              fetch_valid_i;
    logic [3:0]        fetch_count_i;
    logic [7:0][31:0]  fetch_instr_i;
    logic [7:0][63:0]  fetch_pc_i;
    logic              fetch_ready_o;
    logic [7:0]        dec_valid_o;
    logic [7:0][31:0]  dec_instr_o;
    logic [7:0][63:0]  dec_pc_o;
    logic              dec_ready_i;
    logic [5:0]        count_o;
    logic              empty_o;

    fetch_queue8w #(
        .DEPTH (32),
        .LANES (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_count_i (fetch_count_i),
        .fetch_instr_i (fetch_instr_i),
        .fetch_pc_i    (fetch_pc_i),
        .fetch_ready_o (fetch_ready_o),
        .dec_valid_o   (dec_valid_o),
        .dec_instr_o   (dec_instr_o),
        .dec_pc_o      (dec_pc_o),
        .dec_ready_i   (dec_ready_i),
        .count_o       (count_o),
        .empty_o       (empty_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && fetch_valid_i) begin
            assert (fetch_count_i <= 4'd8) else $error("illegal fetch_count_i %0d", fetch_count_i);
        end
    end

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic        valid;
        logic [3:0]  cnt;
        logic [31:0] ibase;
        logic [63:0] pbase;
        logic        ready;
        logic [5:0]  e_count;
        logic [7:0]  e_valid;
        logic        e_fready;
        logic [31:0] e_i0;
        logic [63:0] e_p0;
        logic [31:0] e_i3;
        logic [63:0] e_p3;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic r, input logic f, input logic v, input logic [3:0] c,
                                input logic [31:0] ib, input logic [63:0] pb, input logic rd,
                                input logic [5:0] ec, input logic [7:0] ev, input logic efr,
                                input logic [31:0] i0, input logic [63:0] p0,
                                input logic [31:0] i3, input logic [63:0] p3);
        vec_t t;
        t.rst_n = r;   t.flush = f;    t.valid = v;     t.cnt = c;
        t.ibase = ib;  t.pbase = pb;   t.ready = rd;
        t.e_count = ec; t.e_valid = ev; t.e_fready = efr;
        t.e_i0 = i0;   t.e_p0 = p0;    t.e_i3 = i3;     t.e_p3 = p3;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bundle(input logic [31:0] ib, input logic [63:0] pb);
        for (int i = 0; i < 8; i++) begin
            fetch_instr_i[i] = ib + 32'(i);
            fetch_pc_i[i]    = pb + 64'(4 * i);
        end
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        logic bad;
        bad = (count_o !== v.e_count) || (dec_valid_o !== v.e_valid) ||
              (fetch_ready_o !== v.e_fready) || (empty_o !== (v.e_count == 6'd0)) ||
              (dec_instr_o[0] !== v.e_i0) || (dec_pc_o[0] !== v.e_p0) ||
              (dec_instr_o[3] !== v.e_i3) || (dec_pc_o[3] !== v.e_p3);
        for (int i = 0; i < 8; i++) begin
            if (!v.e_valid[i] && (dec_instr_o[i] !== 32'd0 || dec_pc_o[i] !== 64'd0)) bad = 1'b1;
        end
        n_vec++;
        if (bad) begin
            n_bad++;
            $display("FAIL vec%0d: got cnt=%0d vld=%h rdy=%b emp=%b l0=%h/%h l3=%h/%h, want cnt=%0d vld=%h rdy=%b l0=%h/%h l3=%h/%h",
                     idx, count_o, dec_valid_o, fetch_ready_o, empty_o,
                     dec_instr_o[0], dec_pc_o[0], dec_instr_o[3], dec_pc_o[3],
                     v.e_count, v.e_valid, v.e_fready, v.e_i0, v.e_p0, v.e_i3, v.e_p3);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    logic [31:0] w_i;
    logic [63:0] w_p;
    logic        w_bad;

    initial begin
        // rst flush valid cnt ibase pbase ready | count valid fready lane0 lane3
        vecs.push_back(mk(0,0,0,0, 32'h0,   64'h0,    0, 0,  8'h00,1, 32'h0,   64'h0,    32'h0,   64'h0));
        vecs.push_back(mk(1,0,1,8, 32'h13,  64'h1000, 0, 8,  8'hFF,1, 32'h13,  64'h1000, 32'h16,  64'h100C));
        vecs.push_back(mk(1,0,0,0, 32'h0,   64'h0,    1, 0,  8'h00,1, 32'h0,   64'h0,    32'h0,   64'h0));
        vecs.push_back(mk(1,0,1,3, 32'h100, 64'h2000, 0, 3,  8'h07,1, 32'h100, 64'h2000, 32'h0,   64'h0));
        vecs.push_back(mk(1,0,1,5, 32'h103, 64'h200C, 0, 8,  8'hFF,1, 32'h100, 64'h2000, 32'h103, 64'h200C));
        vecs.push_back(mk(1,0,0,0, 32'h0,   64'h0,    1, 0,  8'h00,1, 32'h0,   64'h0,    32'h0,   64'h0));
        vecs.push_back(mk(1,0,1,8, 32'h200, 64'h3000, 0, 8,  8'hFF,1, 32'h200, 64'h3000, 32'h203, 64'h300C));
        vecs.push_back(mk(1,0,1,8, 32'h208, 64'h3020, 0, 16, 8'hFF,1, 32'h200, 64'h3000, 32'h203, 64'h300C));
        vecs.push_back(mk(1,0,1,8, 32'h210, 64'h3040, 0, 24, 8'hFF,1, 32'h200, 64'h3000, 32'h203, 64'h300C));
        vecs.push_back(mk(1,0,1,1, 32'h218, 64'h3060, 0, 25, 8'hFF,0, 32'h200, 64'h3000, 32'h203, 64'h300C));
        vecs.push_back(mk(1,0,1,8, 32'h300, 64'h9000, 0, 25, 8'hFF,0, 32'h200, 64'h3000, 32'h203, 64'h300C));
        vecs.push_back(mk(1,0,0,0, 32'h0,   64'h0,    1, 17, 8'hFF,1, 32'h208, 64'h3020, 32'h20B, 64'h302C));
        vecs.push_back(mk(1,0,0,0, 32'h0,   64'h0,    1, 9,  8'hFF,1, 32'h210, 64'h3040, 32'h213, 64'h304C));
        vecs.push_back(mk(1,0,0,0, 32'h0,   64'h0,    1, 1,  8'h01,1, 32'h218, 64'h3060, 32'h0,   64'h0));
        vecs.push_back(mk(1,0,0,0, 32'h0,   64'h0,    1, 0,  8'h00,1, 32'h0,   64'h0,    32'h0,   64'h0));
        vecs.push_back(mk(1,0,1,4, 32'h400, 64'h4000, 0, 4,  8'h0F,1, 32'h400, 64'h4000, 32'h403, 64'h400C));
        vecs.push_back(mk(1,0,1,8, 32'h404, 64'h4010, 1, 8,  8'hFF,1, 32'h404, 64'h4010, 32'h407, 64'h401C));
        vecs.push_back(mk(1,0,1,4, 32'h40C, 64'h4030, 0, 12, 8'hFF,1, 32'h404, 64'h4010, 32'h407, 64'h401C));
        vecs.push_back(mk(1,1,1,8, 32'h700, 64'h7000, 1, 0,  8'h00,1, 32'h0,   64'h0,    32'h0,   64'h0));
        vecs.push_back(mk(1,0,1,8, 32'h500, 64'h5000, 0, 8,  8'hFF,1, 32'h500, 64'h5000, 32'h503, 64'h500C));
        vecs.push_back(mk(1,0,1,4, 32'h508, 64'h5020, 0, 12, 8'hFF,1, 32'h500, 64'h5000, 32'h503, 64'h500C));
        vecs.push_back(mk(0,0,1,8, 32'h700, 64'h7000, 1, 0,  8'h00,1, 32'h0,   64'h0,    32'h0,   64'h0));
        vecs.push_back(mk(1,0,1,2, 32'h600, 64'h6000, 0, 2,  8'h03,1, 32'h600, 64'h6000, 32'h0,   64'h0));
        vecs.push_back(mk(1,0,1,0, 32'h777, 64'h7770, 0, 2,  8'h03,1, 32'h600, 64'h6000, 32'h0,   64'h0));
        vecs.push_back(mk(1,0,1,8, 32'h602, 64'h6008, 1, 8,  8'hFF,1, 32'h602, 64'h6008, 32'h605, 64'h6014));
        vecs.push_back(mk(1,0,0,0, 32'h0,   64'h0,    1, 0,  8'h00,1, 32'h0,   64'h0,    32'h0,   64'h0));

        rst_n = 1'b0; flush_i = 1'b0; fetch_valid_i = 1'b0; fetch_count_i = 4'd0; dec_ready_i = 1'b0;
        drive_bundle(32'h0, 64'h0);

        foreach (vecs[n]) begin
            rst_n         = vecs[n].rst_n;
            flush_i       = vecs[n].flush;
            fetch_valid_i = vecs[n].valid;
            fetch_count_i = vecs[n].cnt;
            dec_ready_i   = vecs[n].ready;
            drive_bundle(vecs[n].ibase, vecs[n].pbase);
            step();
            check_vec(n, vecs[n]);
        end

        // Wrap: 70 entries through a 32-deep ring, window must stay contiguous.
        rst_n = 1'b1; flush_i = 1'b0;
        w_i = 32'h800;
        w_p = 64'h8000;
        for (int r = 0; r < 10; r++) begin
            fetch_valid_i = 1'b1; fetch_count_i = 4'd7; dec_ready_i = 1'b0;
            drive_bundle(w_i, w_p);
            #1;
            check_bit($sformatf("wrap%0d_nobypass", r), empty_o, 1'b1);
            step();
            w_bad = (count_o !== 6'd7) || (dec_valid_o !== 8'h7F) ||
                    (dec_instr_o[7] !== 32'd0) || (dec_pc_o[7] !== 64'd0);
            for (int i = 0; i < 7; i++) begin
                if (dec_instr_o[i] !== w_i + 32'(i) || dec_pc_o[i] !== w_p + 64'(4 * i)) w_bad = 1'b1;
            end
            n_vec++;
            if (w_bad) begin
                n_bad++;
                $display("FAIL wrap%0d_window: got cnt=%0d vld=%h l0pc=%h l6pc=%h, want cnt=7 vld=7f l0pc=%h l6pc=%h",
                         r, count_o, dec_valid_o, dec_pc_o[0], dec_pc_o[6], w_p, w_p + 64'd24);
            end
            fetch_valid_i = 1'b0; dec_ready_i = 1'b1;
            step();
            check_bit($sformatf("wrap%0d_drained", r), empty_o, 1'b1);
            w_i = w_i + 32'd7;
            w_p = w_p + 64'd28;
        end

        // Pop on empty must not move head: next push appears at lane 0.
        dec_ready_i = 1'b1; fetch_valid_i = 1'b0;
        step();
        check_bit("pop_empty_noop", (count_o == 6'd0), 1'b1);
        dec_ready_i = 1'b0; fetch_valid_i = 1'b1; fetch_count_i = 4'd1;
        drive_bundle(w_i, w_p);
        step();
        n_vec++;
        if (dec_valid_o !== 8'h01 || dec_pc_o[0] !== w_p || dec_instr_o[0] !== w_i) begin
            n_bad++;
            $display("FAIL after_empty_pop: got vld=%h l0=%h/%h want vld=01 l0=%h/%h",
                     dec_valid_o, dec_instr_o[0], dec_pc_o[0], w_i, w_p);
        end
        fetch_valid_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue8w.md
Name: fetch_queue8w

Overview:
- Instruction buffer between the fetch unit and the 8-wide decoder.
- Accepts packed fetch bundles of 0–8 instruction words with their PCs and stores them in a circular buffer.
- Presents the oldest up to 8 entries per cycle on lanes shaped as the decoder's `instr_i`/`pc_i` inputs, plus per-lane valids.
- Decouples fetch bubbles from decode stalls; supports a pipeline flush.

Parameters:
- DEPTH, 32, queue entries; power of two, ≥ 16.
- LANES, 8, bundle width on both sides; fixed at 8.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush_i  in  1  discard all contents
- fetch_valid_i  in  1  push request
- fetch_count_i  in  4  number of valid packed lanes, 0..8
- fetch_instr_i  in  32 x 8  instruction words; lane 0 is oldest
- fetch_pc_i  in  64 x 8  PC per lane
- fetch_ready_o  out  1  queue can accept a full bundle
- dec_valid_o  out  1 x 8  lane i holds valid data
- dec_instr_o  out  32 x 8  oldest entries, head first
- dec_pc_o  out  64 x 8  PCs matching dec_instr_o
- dec_ready_i  in  1  decoder consumes all valid lanes this cycle
- count_o  out  log2(DEPTH)+1  current occupancy
- empty_o  out  1  count_o == 0

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-low on `rst_n`, sampled on the `clk` rising edge.
- Reset values: head = 0, tail = 0, count = 0.
  - Outputs under reset: fetch_ready_o = 1, dec_valid_o all 0, dec_instr_o/dec_pc_o all 0, count_o = 0, empty_o = 1.
  - Storage array is not reset.
- Pointers and wrap:
  - head and tail are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is held explicitly, range 0..DEPTH.
- fetch_ready_o = (DEPTH − count ≥ 8), computed from the registered count only.
  - It does not use the same-cycle pop, so it has no combinational path from dec_ready_i.
- Push:
  - Push occurs when fetch_valid_i & fetch_ready_o & !flush_i.
  - Lane k < fetch_count_i is written to entry (tail+k) mod DEPTH.
  - tail += fetch_count_i.
  - fetch_count_i = 0 is a legal no-op.
  - Values 9–15 are illegal: the bench asserts on them, and RTL clamps to 8.
  - fetch_valid_i while fetch_ready_o = 0 is dropped; fetch must hold the bundle.
- Output lanes:
  - dec_valid_o[i] = (i < count).
  - dec_instr_o[i] / dec_pc_o[i] = entry (head+i) mod DEPTH when valid, else 0.
  - Lanes are driven combinationally from registered state only.
- Pop:
  - Pop occurs when dec_ready_i & !flush_i.
  - npop = min(count, 8); head += npop.
  - dec_ready_i with count = 0 is a no-op.
- Same-cycle push and pop: count_next = count + npush − npop.
- Latency: an entry pushed in cycle N is visible on dec lanes in cycle N+1 at the earliest. No bypass.
- Flush:
  - flush_i forces head = tail = 0 and count = 0 next cycle.
  - It has priority over any same-cycle push or pop, and both are discarded.
  - Outputs are invalid from the next cycle.
- Reset mid-operation: identical to flush; all pending entries are lost.
- Full: with count > DEPTH−8, pushes are refused even if the bundle would fit. This is conservative by design.
- Ordering: strict FIFO. Lane 0 of the output is always the oldest entry.

Decomposition:
- Shared package `fetch_pkg`:
  - FETCH_LANES = 8.
  - `fetch_entry_t` struct {instr[31:0], pc[63:0]}.
  - Count-width helper constant.
- Sub-module `ring_rdport8`: combinational 8-lane modulo-indexed read from the storage array given head. It is reusable for the write-offset mux.
- Everything else stays inline: pointer/count registers, write enables, flush.

Test Plan:
- Reset, then push count=8 with instr 0x00000013+i, pc 0x1000+4i; dec_ready_i=0 → next cycle dec_valid_o = 0xFF, lane 3 = {0x00000016, 0x100C}, count_o = 8.
- Push count=3, then count=5; dec_ready_i=1 only on cycle 3 → all 8 lanes popped in FIFO order across the bundle boundary; empty_o = 1 afterwards.
- Fill to count=25 (DEPTH=32) → fetch_ready_o = 0; a push attempted in that state is ignored and count stays 25. Pop 8 → ready = 1 the following cycle.
- Wrap test: 10 rounds of push 7 / pop 8 → tail crosses entry 31→0; output PCs stay contiguous, with no duplicates or gaps.
- Same-cycle push 8 + pop with count=4 → count_o = 8, and the new head lane 0 is the first pushed entry.
- flush_i together with push 8 and pop at count=12 → next cycle count_o = 0, dec_valid_o = 0, fetch_ready_o = 1. The same check holds with rst_n low instead of flush.
